sensor_stream_scheduler: RTL and testbench



---
 rtl/sensor_stream_scheduler_pkg.sv | 36 +++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/sensor_stream_scheduler.sv | 117 +++++++++++
 tb/tb_sensor_stream_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_stream_scheduler_pkg.sv
// Shared sizes, state encoding and frame header layout for the sensor stream scheduler.
package sensor_stream_scheduler_pkg;

    localparam int unsigned NUM_STREAMS  = 8;
    localparam int unsigned ID_WIDTH     = 3;
    localparam int unsigned DATA_WIDTH   = 110;
    localparam int unsigned NUM_BYTES    = 14;
    localparam int unsigned SHIFT_WIDTH  = NUM_BYTES * 8;
    localparam int unsigned CNT_WIDTH    = 4;
    localparam int unsigned FRAMES_WIDTH = 16;

    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HEADER = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    // Header byte: tag nibble, one reserved zero bit, stream id.
    typedef struct packed {
        logic [3:0]          tag;
        logic                rsvd;
        logic [ID_WIDTH-1:0] id;
    } header_t;

    function automatic logic [7:0] make_header(input logic [ID_WIDTH-1:0] id);
        header_t h;
        h.tag  = HDR_TAG;
        h.rsvd = 1'b0;
        h.id   = id;
        return h;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin finder: first set request bit at or above start, wrapping.
module rr_priority_pick
    import sensor_stream_scheduler_pkg::*;
(
    input  logic [NUM_STREAMS-1:0] request,
    input  logic [ID_WIDTH-1:0]    start,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   any
);

    logic [ID_WIDTH-1:0] w_idx;
    logic                w_found;

    always_comb begin
        grant_id = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        any      = |request;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            w_idx = ID_WIDTH'(start + ID_WIDTH'(k));
            if (!w_found && request[w_idx]) begin
                grant_id = w_idx;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_stream_scheduler.sv
// Round-robin scheduler: grants one ready ion stream, captures its word and
// streams it out as a 15-byte frame (header + 14 data bytes, MSB first).
module sensor_stream_scheduler
    import sensor_stream_scheduler_pkg::*;
(
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NUM_STREAMS-1:0]  stream_ready,
    input  logic [NUM_STREAMS-1:0]  enable_mask,
    input  logic [DATA_WIDTH-1:0]   stream_data,
    output logic [ID_WIDTH-1:0]     stream_sel,
    output logic [NUM_STREAMS-1:0]  stream_ack,
    output logic [7:0]              byte_out,
    output logic                    byte_valid,
    input  logic                    byte_accept,
    output logic                    busy,
    output logic [FRAMES_WIDTH-1:0] frames_sent
);

    state_t                  r_state;
    logic [ID_WIDTH-1:0]     r_rr_ptr;
    logic [ID_WIDTH-1:0]     r_stream_sel;
    logic [NUM_STREAMS-1:0]  r_stream_ack;
    logic [SHIFT_WIDTH-1:0]  r_shift;
    logic [CNT_WIDTH-1:0]    r_byte_cnt;
    logic [7:0]              r_byte_out;
    logic                    r_byte_valid;
    logic                    r_busy;
    logic [FRAMES_WIDTH-1:0] r_frames_sent;

    logic [NUM_STREAMS-1:0]  w_eligible;
    logic [ID_WIDTH-1:0]     w_pick_id;
    logic                    w_pick_any;
    logic                    w_last_byte;

    assign w_eligible  = stream_ready & enable_mask;
    assign w_last_byte = (r_byte_cnt == CNT_WIDTH'(NUM_BYTES - 1));

    rr_priority_pick u_pick (
        .request  (w_eligible),
        .start    (r_rr_ptr),
        .grant_id (w_pick_id),
        .any      (w_pick_any)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_stream_sel  <= '0;
            r_stream_ack  <= '0;
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_byte_out    <= '0;
            r_byte_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            // Ack is a single-cycle pulse; only SETTLE raises it.
            r_stream_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_stream_sel <= w_pick_id;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!stream_ready[r_stream_sel]) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_shift      <= SHIFT_WIDTH'(stream_data);
                        r_stream_ack <= NUM_STREAMS'(1) << r_stream_sel;
                        r_byte_out   <= make_header(r_stream_sel);
                        r_byte_valid <= 1'b1;
                        r_state      <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (byte_accept) begin
                        r_byte_out <= r_shift[SHIFT_WIDTH-1 -: 8];
                        r_byte_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_accept) begin
                        if (w_last_byte) begin
                            r_byte_out    <= '0;
                            r_byte_valid  <= 1'b0;
                            r_busy        <= 1'b0;
                            r_rr_ptr      <= ID_WIDTH'(r_stream_sel + ID_WIDTH'(1));
                            r_frames_sent <= FRAMES_WIDTH'(r_frames_sent + FRAMES_WIDTH'(1));
                            r_state       <= ST_IDLE;
                        end else begin
                            // Present the next byte now so byte_out tracks the shifted MSB byte.
                            r_shift    <= r_shift << 8;
                            r_byte_out <= r_shift[SHIFT_WIDTH-9 -: 8];
                            r_byte_cnt <= CNT_WIDTH'(r_byte_cnt + CNT_WIDTH'(1));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stream_sel  = r_stream_sel;
    assign stream_ack  = r_stream_ack;
    assign byte_out    = r_byte_out;
    assign byte_valid  = r_byte_valid;
    assign busy        = r_busy;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_sensor_stream_scheduler.sv
// Self-checking bench for sensor_stream_scheduler: vector table plus byte scoreboard.
module tb_sensor_stream_scheduler;

    logic         clock;
    logic         resetn;
    logic [7:0]   stream_ready;
    logic [7:0]   enable_mask;
    logic [109:0] stream_data;
    logic [2:0]   stream_sel;
    logic [7:0]   stream_ack;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_accept;
    logic         busy;
    logic [15:0]  frames_sent;

    sensor_stream_scheduler dut (
        .clock        (clock),
        .resetn       (resetn),
        .stream_ready (stream_ready),
        .enable_mask  (enable_mask),
        .stream_data  (stream_data),
        .stream_sel   (stream_sel),
        .stream_ack   (stream_ack),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_accept  (byte_accept),
        .busy         (busy),
        .frames_sent  (frames_sent)
    );

    typedef struct {
        logic [7:0] ready;
        logic [7:0] mask;
        int         mode;
        logic [2:0] id;
    } vec_t;

    logic [109:0] mem [8];
    assign stream_data = mem[stream_sel];

    logic [7:0]  exp_q[$];
    logic [2:0]  ack_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          ack_cnt  = 0;
    int          valid_seen = 0;
    int          popped   = 0;
    int          accept_mode = 0;
    int          cyc = 0;
    logic [7:0]  last_ack = '0;
    logic [2:0]  last_sel = '0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_byte = '0;
    logic [15:0] exp_frames = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [2:0] id);
        logic [111:0] w;
        logic [7:0]   hdr;
        hdr = {4'hA, 1'b0, id};
        w   = {2'b00, mem[id]};
        exp_q.push_back(hdr);
        for (int b = 0; b < 14; b++) exp_q.push_back(w[111 - 8*b -: 8]);
    endtask

    task automatic wait_frames(input logic [15:0] target, input string name);
        int n = 0;
        while (frames_sent !== target && n < 600) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(frames_sent), 32'(target));
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // UART side: accept pattern, changed just after each rising edge.
    initial begin
        byte_accept = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            case (accept_mode)
                0:       byte_accept = 1'b1;
                1:       byte_accept = (cyc % 3 == 0);
                default: byte_accept = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard pops, ack logging and hold-stability checks.
    initial begin
        forever begin
            @(negedge clock);
            if (!resetn) begin
                prev_hold = 1'b0;
            end else begin
                if (stream_ack != 8'h00) begin
                    ack_cnt++;
                    last_ack = stream_ack;
                    last_sel = stream_sel;
                    ack_log.push_back(stream_sel);
                end
                if (byte_valid) valid_seen++;
                if (prev_hold) check("hold_stable", 32'({byte_valid, byte_out}), 32'({1'b1, prev_byte}));
                if (byte_valid && byte_accept) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got %0h expected none", byte_out);
                    end else begin
                        check("frame_byte", 32'(byte_out), 32'(exp_q.pop_front()));
                    end
                    popped++;
                end
                prev_hold = byte_valid && !byte_accept;
                prev_byte = byte_out;
            end
        end
    end

    initial begin
        vec_t         vecs[8];
        logic [111:0] tmp;
        int           p0;
        int           n;

        vecs[0] = '{8'h04, 8'hFF, 0, 3'd2};
        vecs[1] = '{8'h09, 8'hFF, 0, 3'd3};
        vecs[2] = '{8'h09, 8'hF7, 0, 3'd0};
        vecs[3] = '{8'h81, 8'hFF, 1, 3'd7};
        vecs[4] = '{8'hFF, 8'hFF, 0, 3'd0};
        vecs[5] = '{8'h60, 8'h3F, 0, 3'd5};
        vecs[6] = '{8'h22, 8'hFF, 1, 3'd1};
        vecs[7] = '{8'h80, 8'hFF, 0, 3'd7};

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 14; b++) tmp[8*b +: 8] = 8'($urandom);
            mem[i] = tmp[109:0];
        end
        mem[2] = 110'h1;
        mem[7] = '1;

        resetn       = 1'b0;
        stream_ready = '0;
        enable_mask  = '0;
        repeat (3) @(negedge clock);
        check("rst_sel",    32'(stream_sel),  32'd0);
        check("rst_ack",    32'(stream_ack),  32'd0);
        check("rst_byte",   32'(byte_out),    32'd0);
        check("rst_valid",  32'(byte_valid),  32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Table-driven single frames.
        for (int v = 0; v < 8; v++) begin
            accept_mode = vecs[v].mode;
            enable_mask = vecs[v].mask;
            ack_cnt     = 0;
            push_frame(vecs[v].id);
            exp_frames  = exp_frames + 16'd1;
            stream_ready = vecs[v].ready;
            wait_frames(exp_frames, "vec_frames");
            stream_ready = '0;
            check("vec_ack_cnt", 32'(ack_cnt),      32'd1);
            check("vec_ack",     32'(last_ack),     32'(8'h01 << vecs[v].id));
            check("vec_sel",     32'(last_sel),     32'(vecs[v].id));
            check("vec_q_empty", 32'(exp_q.size()), 32'd0);
            repeat (2) @(negedge clock);
        end

        // Streams 0 and 7 held ready: strict alternation.
        accept_mode = 0;
        enable_mask = 8'hFF;
        ack_log.delete();
        push_frame(3'd0); push_frame(3'd7); push_frame(3'd0); push_frame(3'd7);
        exp_frames = exp_frames + 16'd4;
        stream_ready = 8'h81;
        wait_frames(exp_frames, "rr_frames");
        stream_ready = '0;
        check("rr_ack_n", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            check("rr_g0", 32'(ack_log[0]), 32'd0);
            check("rr_g1", 32'(ack_log[1]), 32'd7);
            check("rr_g2", 32'(ack_log[2]), 32'd0);
            check("rr_g3", 32'(ack_log[3]), 32'd7);
        end
        check("rr_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);

        // Masked-out ready stream must never be granted.
        ack_cnt = 0;
        valid_seen = 0;
        enable_mask = 8'hFE;
        stream_ready = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("mask_busy", 32'(busy), 32'd0);
        end
        check("mask_ack",   32'(ack_cnt),    32'd0);
        check("mask_valid", 32'(valid_seen), 32'd0);
        stream_ready = '0;
        enable_mask  = 8'hFF;
        @(negedge clock);

        // One-cycle ready pulse: abort in SETTLE.
        stream_ready = 8'h08;
        @(negedge clock);
        stream_ready = '0;
        check("abort_sel",  32'(stream_sel), 32'd3);
        check("abort_busy", 32'(busy),       32'd1);
        repeat (6) @(negedge clock);
        check("abort_ack",    32'(ack_cnt),     32'd0);
        check("abort_valid",  32'(valid_seen),  32'd0);
        check("abort_idle",   32'(busy),        32'd0);
        check("abort_frames", 32'(frames_sent), 32'(exp_frames));

        // Pointer must be unchanged by the abort: 0 wins over 7.
        push_frame(3'd0);
        exp_frames = exp_frames + 16'd1;
        stream_ready = 8'h81;
        wait_frames(exp_frames, "post_abort_frames");
        stream_ready = '0;
        check("post_abort_ack", 32'(last_ack), 32'h01);
        repeat (2) @(negedge clock);

        // Reset in the middle of a frame.
        p0 = popped;
        push_frame(3'd2);
        stream_ready = 8'h04;
        n = 0;
        while (popped < p0 + 6 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("mid_reached", 32'(popped >= p0 + 6), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_sel",    32'(stream_sel),  32'd0);
        check("mid_ack",    32'(stream_ack),  32'd0);
        check("mid_byte",   32'(byte_out),    32'd0);
        check("mid_valid",  32'(byte_valid),  32'd0);
        check("mid_busy",   32'(busy),        32'd0);
        check("mid_frames", 32'(frames_sent), 32'd0);
        exp_q.delete();
        exp_frames = 16'd0;
        ack_cnt = 0;
        push_frame(3'd2);
        exp_frames = 16'd1;
        @(negedge clock);
        resetn = 1'b1;
        wait_frames(exp_frames, "post_rst_frames");
        stream_ready = '0;
        check("post_rst_ack_cnt", 32'(ack_cnt),      32'd1);
        check("post_rst_sel",     32'(last_sel),     32'd2);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);

        // Counter wrap: preload the counter to its maximum while idle.
        force dut.r_frames_sent = 16'hFFFF;
        @(negedge clock);
        release dut.r_frames_sent;
        @(negedge clock);
        push_frame(3'd4);
        stream_ready = 8'h10;
        wait_frames(16'h0000, "wrap_frames");
        stream_ready = '0;
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
